// File: rtl/mem_arbiter.sv
// Two-port request arbiter in front of a single-transaction memory port.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; otherwise PRIO_PORT wins ties.
module mem_arbiter #(
  parameter int unsigned PRIO_PORT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  p0_rw_flag,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_write_data,
  input  logic [3:0]  p0_write_mask,
  output logic [31:0] p0_read_data,
  output logic        p0_done,
  output logic        p0_busy,
  input  logic [1:0]  p1_rw_flag,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_write_data,
  input  logic [3:0]  p1_write_mask,
  output logic [31:0] p1_read_data,
  output logic        p1_done,
  output logic        p1_busy,
  output logic [1:0]  mem_rw_flag,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_busy,
  input  logic        mem_done,
  output logic        protocol_err
);

  localparam logic PRIO = 1'(PRIO_PORT);

  typedef enum logic [1:0] {IDLE, WAIT0, WAIT1} state_t;

  state_t      state, state_nxt;
  logic [1:0]  buf_valid;
  logic [1:0]  buf_rw    [2];
  logic [31:0] buf_addr  [2];
  logic [31:0] buf_wdata [2];
  logic [3:0]  buf_mask  [2];
  logic [1:0]  req_rw    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_mask  [2];
  logic [1:0]  req_pulse;
  logic [1:0]  cap_ok;
  logic        issue;
  logic        grant;
  logic        tie_pick;

`ifdef MEM_ARBITER_RR_EN
  logic rr_ptr;

  // Round-robin pointer points away from the most recent grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        rr_ptr <= PRIO;
    else if (issue) rr_ptr <= ~grant;
  end

  assign tie_pick = rr_ptr;
`else
  assign tie_pick = PRIO;
`endif

  // A port may capture on the cycle its own transaction completes.
  always_comb begin
    req_rw[0]    = p0_rw_flag;
    req_rw[1]    = p1_rw_flag;
    req_addr[0]  = p0_addr;
    req_addr[1]  = p1_addr;
    req_wdata[0] = p0_write_data;
    req_wdata[1] = p1_write_data;
    req_mask[0]  = p0_write_mask;
    req_mask[1]  = p1_write_mask;
    req_pulse    = {|p1_rw_flag, |p0_rw_flag};
    cap_ok[0]    = !buf_valid[0] && !(state == WAIT0 && !mem_done);
    cap_ok[1]    = !buf_valid[1] && !(state == WAIT1 && !mem_done);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf_valid    <= '0;
      protocol_err <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_rw[i]    <= '0;
        buf_addr[i]  <= '0;
        buf_wdata[i] <= '0;
        buf_mask[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (issue && grant == 1'(i)) buf_valid[i] <= 1'b0;
        if (req_pulse[i] && cap_ok[i]) begin
          buf_valid[i] <= 1'b1;
          buf_rw[i]    <= (req_rw[i] == 2'b11) ? 2'b01 : req_rw[i];
          buf_addr[i]  <= req_addr[i];
          buf_wdata[i] <= req_wdata[i];
          buf_mask[i]  <= req_mask[i];
        end
      end
      protocol_err <= protocol_err | (|(req_pulse & ~cap_ok));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    mem_rw_flag    = '0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_write_mask = '0;
    p0_done        = 1'b0;
    p1_done        = 1'b0;
    p0_read_data   = '0;
    p1_read_data   = '0;
    issue          = (state == IDLE) && !mem_busy && (|buf_valid);
    grant          = (buf_valid == 2'b11) ? tie_pick : buf_valid[1];

    case (state)
      IDLE: begin
        if (issue) begin
          state_nxt      = grant ? WAIT1 : WAIT0;
          mem_rw_flag    = buf_rw[grant];
          mem_addr       = buf_addr[grant];
          mem_write_data = buf_wdata[grant];
          mem_write_mask = buf_mask[grant];
        end
      end
      WAIT0: begin
        p0_done      = mem_done;
        p0_read_data = mem_read_data;
        if (mem_done) state_nxt = IDLE;
      end
      WAIT1: begin
        p1_done      = mem_done;
        p1_read_data = mem_read_data;
        if (mem_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    p0_busy = buf_valid[0] | (state == WAIT0);
    p1_busy = buf_valid[1] | (state == WAIT1);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default PRIO_PORT=1; RR expectations when MEM_ARBITER_RR_EN is defined).
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  p0_rw_flag, p1_rw_flag;
  logic [31:0] p0_addr, p0_write_data, p1_addr, p1_write_data;
  logic [3:0]  p0_write_mask, p1_write_mask;
  logic [31:0] p0_read_data, p1_read_data;
  logic        p0_done, p0_busy, p1_done, p1_busy;
  logic [1:0]  mem_rw_flag;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_write_mask;
  logic        mem_busy, mem_done, protocol_err;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .p0_rw_flag(p0_rw_flag), .p0_addr(p0_addr), .p0_write_data(p0_write_data),
    .p0_write_mask(p0_write_mask), .p0_read_data(p0_read_data), .p0_done(p0_done), .p0_busy(p0_busy),
    .p1_rw_flag(p1_rw_flag), .p1_addr(p1_addr), .p1_write_data(p1_write_data),
    .p1_write_mask(p1_write_mask), .p1_read_data(p1_read_data), .p1_done(p1_done), .p1_busy(p1_busy),
    .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask), .mem_read_data(mem_read_data), .mem_busy(mem_busy),
    .mem_done(mem_done), .protocol_err(protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulse(input logic port, input logic [1:0] rw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
    if (port) begin
      p1_rw_flag = rw; p1_addr = addr; p1_write_data = wdata; p1_write_mask = mask;
    end else begin
      p0_rw_flag = rw; p0_addr = addr; p0_write_data = wdata; p0_write_mask = mask;
    end
  endtask

  task automatic clear_req();
    p0_rw_flag = 2'b00;
    p1_rw_flag = 2'b00;
  endtask

  // One tie-round step: the issue cycle is current; check winner, then complete it,
  // optionally re-pulsing the completing port on its done cycle.
  task automatic round(input string tag, input logic [31:0] exp_addr, input logic port,
                       input logic rep, input logic [31:0] rep_addr);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    tick();
    mem_done = 1'b1;
    if (rep) pulse(port, 2'b01, rep_addr, 32'h0, 4'h0);
    settle();
    chk({tag, "_done"}, 32'(port ? p1_done : p0_done), 32'd1);
    tick();
    mem_done = 1'b0;
    clear_req();
    settle();
  endtask

  initial begin
    RST = 1'b1;
    clear_req();
    p0_addr = '0; p0_write_data = '0; p0_write_mask = '0;
    p1_addr = '0; p1_write_data = '0; p1_write_mask = '0;
    mem_read_data = '0; mem_busy = 1'b0; mem_done = 1'b0;
    tick(); tick();
    chk("rst_mem_rw", 32'(mem_rw_flag), 32'd0);
    chk("rst_p0_busy", 32'(p0_busy), 32'd0);
    chk("rst_p1_busy", 32'(p1_busy), 32'd0);
    chk("rst_perr", 32'(protocol_err), 32'd0);
    RST = 1'b0;
    tick();

    // Single read on p0
    pulse(1'b0, 2'b01, 32'h100, 32'h0, 4'h0);
    settle();
    chk("rd_same_cycle", 32'(mem_rw_flag), 32'd0);
    tick(); clear_req(); settle();
    chk("rd_rw", 32'(mem_rw_flag), 32'd1);
    chk("rd_addr", mem_addr, 32'h100);
    chk("rd_busy", 32'(p0_busy), 32'd1);
    tick();
    chk("rd_wait_rw", 32'(mem_rw_flag), 32'd0);
    chk("rd_wait_done", 32'(p0_done), 32'd0);
    mem_done = 1'b1; mem_read_data = 32'hDEADBEEF;
    settle();
    chk("rd_done", 32'(p0_done), 32'd1);
    chk("rd_data", p0_read_data, 32'hDEADBEEF);
    chk("rd_p1_done", 32'(p1_done), 32'd0);
    tick(); mem_done = 1'b0; settle();
    chk("rd_busy_after", 32'(p0_busy), 32'd0);
    chk("rd_data_idle", p0_read_data, 32'd0);

    // Write on p1
    pulse(1'b1, 2'b10, 32'h40, 32'h12345678, 4'b0011);
    tick(); clear_req(); settle();
    chk("wr_rw", 32'(mem_rw_flag), 32'd2);
    chk("wr_addr", mem_addr, 32'h40);
    chk("wr_wdata", mem_write_data, 32'h12345678);
    chk("wr_mask", 32'(mem_write_mask), 32'h3);
    tick();
    chk("wr_busy1", 32'(p1_busy), 32'd1);
    tick();
    chk("wr_busy2", 32'(p1_busy), 32'd1);
    mem_done = 1'b1; settle();
    chk("wr_done", 32'(p1_done), 32'd1);
    tick(); mem_done = 1'b0; settle();
    chk("wr_busy_after", 32'(p1_busy), 32'd0);

    // rw=2'b11 captured as a read
    pulse(1'b0, 2'b11, 32'h80, 32'h0, 4'h0);
    tick(); clear_req(); settle();
    chk("rw11_as_read", 32'(mem_rw_flag), 32'd1);
    tick(); mem_done = 1'b1; tick(); mem_done = 1'b0; settle();

    // Tie rounds: winner re-pulses on its done cycle to keep both buffers full
    pulse(1'b0, 2'b01, 32'hA0, 32'h0, 4'h0);
    pulse(1'b1, 2'b01, 32'hB0, 32'h0, 4'h0);
    tick(); clear_req(); settle();
`ifdef MEM_ARBITER_RR_EN
    round("tie1", 32'hB0, 1'b1, 1'b1, 32'hB1);
    round("tie2", 32'hA0, 1'b0, 1'b1, 32'hA1);
    round("tie3", 32'hB1, 1'b1, 1'b0, 32'h0);
    round("tie4", 32'hA1, 1'b0, 1'b0, 32'h0);
`else
    round("tie1", 32'hB0, 1'b1, 1'b1, 32'hB1);
    round("tie2", 32'hB1, 1'b1, 1'b1, 32'hB2);
    round("tie3", 32'hB2, 1'b1, 1'b0, 32'h0);
    round("tie4", 32'hA0, 1'b0, 1'b0, 32'h0);
`endif
    chk("tie_idle_rw", 32'(mem_rw_flag), 32'd0);

    // mem_busy stalls issue for 4 cycles
    mem_busy = 1'b1;
    pulse(1'b0, 2'b01, 32'h200, 32'h0, 4'h0);
    tick(); clear_req(); settle();
    chk("stall_c1", 32'(mem_rw_flag), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_cn", 32'(mem_rw_flag), 32'd0);
    end
    mem_busy = 1'b0; settle();
    chk("stall_release_rw", 32'(mem_rw_flag), 32'd1);
    chk("stall_release_addr", mem_addr, 32'h200);
    tick(); mem_done = 1'b1; tick(); mem_done = 1'b0; settle();

    // Protocol error while in flight, then reset mid-WAIT0
    pulse(1'b0, 2'b01, 32'h300, 32'h0, 4'h0);
    tick(); clear_req(); settle();
    chk("perr_issue", mem_addr, 32'h300);
    tick();
    pulse(1'b0, 2'b01, 32'h304, 32'h0, 4'h0);
    tick(); clear_req(); settle();
    chk("perr_flag", 32'(protocol_err), 32'd1);
    chk("perr_no_issue", 32'(mem_rw_flag), 32'd0);
    chk("perr_busy", 32'(p0_busy), 32'd1);
    RST = 1'b1; settle();
    chk("mid_rst_rw", 32'(mem_rw_flag), 32'd0);
    chk("mid_rst_busy", 32'(p0_busy), 32'd0);
    chk("mid_rst_perr", 32'(protocol_err), 32'd0);
    mem_done = 1'b1; mem_read_data = 32'h5555AAAA; settle();
    chk("mid_rst_done", 32'(p0_done), 32'd0);
    chk("mid_rst_rdata", p0_read_data, 32'd0);
    tick(); RST = 1'b0; tick(); settle();
    chk("post_rst_done", 32'(p0_done), 32'd0);
    chk("post_rst_rw", 32'(mem_rw_flag), 32'd0);
    mem_done = 1'b0;
    tick();
    chk("post_rst_busy", 32'(p0_busy), 32'd0);
    chk("post_rst_rw2", 32'(mem_rw_flag), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter PRIO_PORT, default 1, meaning the port (0 or 1) that wins fixed-priority ties; it is also the first grant after reset in round-robin mode.
REQ-002 SHALL have ports: CLK  in  1  clock; RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have, for each port x in {0,1}: px_rw_flag  in  2  request pulse ([0] read, [1] write).
REQ-004 px_addr  in  32  word address; px_write_data  in  32; px_write_mask  in  4  byte enables.
REQ-005 px_read_data  out  32  read data; px_done  out  1  completion pulse; px_busy  out  1  request buffered or in flight.
REQ-006 Memory side: mem_rw_flag  out  2; mem_addr  out  32; mem_write_data  out  32; mem_write_mask  out  4.
REQ-007 Memory side: mem_read_data  in  32; mem_busy  in  1; mem_done  in  1.
REQ-008 protocol_err  out  1  sticky flag for an illegal request.

Function
REQ-009 SHALL hold one request buffer per port (valid, rw, addr, wdata, mask); a pulse with px_rw_flag!=0 SHALL be captured at the next edge when that port is neither buffered nor in flight.
REQ-010 px_rw_flag==2'b11 SHALL be captured as a read (2'b01).
REQ-011 SHALL implement states IDLE, WAIT0, WAIT1.
REQ-012 In IDLE with !mem_busy and at least one buffer valid, SHALL drive the winner's buffer combinationally onto mem_* for exactly that cycle, clear that buffer, and enter WAITx at the next edge.
REQ-013 In all other cycles mem_rw_flag, mem_addr, mem_write_data and mem_write_mask SHALL be 0.
REQ-014 Latency: a request pulse in cycle N on an idle arbiter SHALL appear on mem_rw_flag in cycle N+1.
REQ-015 In WAITx, px_done SHALL equal mem_done and px_read_data SHALL equal mem_read_data combinationally; otherwise both SHALL be 0.
REQ-016 On mem_done in WAITx, SHALL return to IDLE at the next edge.
REQ-017 A request pulse from port x in the same cycle as its done SHALL be captured and issued no earlier than the following cycle.
REQ-018 mem_done in IDLE SHALL be ignored.
REQ-019 px_busy SHALL be 1 while port x's buffer is valid or state==WAITx.
REQ-020 A pulse from port x while px_busy==1 SHALL be dropped and SHALL set protocol_err, which stays set until reset.
REQ-021 Simultaneous valid buffers SHALL be resolved per REQ-025/REQ-026.

Reset
REQ-022 RST SHALL asynchronously force IDLE, clear both buffers and protocol_err, and set the round-robin pointer to PRIO_PORT.
REQ-023 While RST is high, all outputs SHALL be 0.
REQ-024 A transaction in flight at reset SHALL be abandoned; its later mem_done SHALL be ignored per REQ-018.

Configuration
REQ-025 With MEM_ARBITER_RR_EN defined, ties SHALL go to the round-robin pointer port, and the pointer SHALL flip to the other port after each grant.
REQ-026 Without MEM_ARBITER_RR_EN, ties SHALL always go to PRIO_PORT and no pointer register SHALL exist.

Verification
REQ-027 Single read: p0 pulse rw=1, addr=0x100 at cycle 5 -> mem_rw_flag=1, mem_addr=0x100 at cycle 6; mem_done with data 0xDEADBEEF -> p0_done=1, p0_read_data=0xDEADBEEF in the same cycle.
REQ-028 Write: p1 rw=2, addr=0x40, wdata=0x12345678, mask=4'b0011 -> forwarded unchanged one cycle later; p1_busy=1 until mem_done.
REQ-029 Tie, RR disabled, PRIO_PORT=1: both ports pulse in the same cycle -> p1 issued first, p0 issued the cycle after p1's done plus one; repeated ties always favour p1.
REQ-030 Tie, MEM_ARBITER_RR_EN defined: three back-to-back tie rounds -> grant order p1, p0, p1.
REQ-031 mem_busy held high for 4 cycles with p0 buffered -> no mem_rw_flag pulse until the cycle mem_busy falls.
REQ-032 p0 pulses again while in flight -> protocol_err=1 and the second request is never issued; RST asserted mid-WAIT0 -> all outputs 0, and a subsequent mem_done does not produce p0_done.
